fifo_uart_tx: RTL and testbench

Downstream consumer of the 16-deep byte FIFO. It pops one byte whenever the FIFO is non-empty and the block is enabled, then serialises the byte onto a single UART line as 8N1, LSB first. The FIFO's full and empty flags come from its occupancy counter, and this block is the FIFO's only reader.

---
 rtl/fifo_uart_pkg.sv | 26 ++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/fifo_uart_tx.sv | 139 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg
// Shared definitions for the FIFO-draining UART transmitter.
//   state_t         : transmitter FSM states
//   DEFAULT_DATA_W  : default byte width (matches the FIFO din width)
//   TX_IDLE         : level of the serial line when nothing is being sent
//   last_bit_idx()  : index of the final data bit for a given byte width
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam int   DEFAULT_DATA_W = 8;
  localparam logic TX_IDLE        = 1'b1;

  // Value the 3-bit data-bit counter holds while the last data bit is on the line.
  function automatic logic [2:0] last_bit_idx(input int width);
    return 3'(width - 1);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
// Free-running bit-period counter for the UART transmitter.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   clear    : holds the counter at zero (used while no bit is being timed)
//   bit_tick : high on the terminal count, i.e. the last clock of a bit period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] clk_cnt_r;

  // Count clocks within a bit, wrapping at the terminal value.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      clk_cnt_r <= {CW{1'b0}};
    end else if (clk_cnt_r == TERM) begin
      clk_cnt_r <= {CW{1'b0}};
    end else begin
      clk_cnt_r <= clk_cnt_r + ONE;
    end
  end

  assign bit_tick = (clk_cnt_r == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Sole reader of the 16-deep byte FIFO. Pops one byte at a time while enabled
// and sends it as 8N1, LSB first, on a single UART line.
// Ports:
//   clk        : system clock (posedge)
//   rst        : synchronous active-high reset
//   en         : transmit enable, only looked at between frames
//   fifo_empty : FIFO empty flag
//   fifo_dout  : FIFO read data, valid the cycle after fifo_rd
//   fifo_rd    : one-cycle pop strobe per byte
//   tx         : serial line, idles high
//   busy       : high whenever a pop or frame is in progress
//   frame_done : one-cycle pulse in the final cycle of the stop bit
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] LAST_BIT = last_bit_idx(DATA_W);

  state_t            state_r;
  logic [DATA_W-1:0] shift_r;
  logic [2:0]        bit_cnt_r;
  logic              tx_r;
  logic              fifo_rd_r;
  logic              busy_r;
  logic              clear_s;
  logic              bit_tick_s;

  // Bit timer runs only while a frame is on the line; otherwise held at zero
  // so the start bit always begins from a fresh count.
  always_comb begin
    clear_s = 1'b1;
    case (state_r)
      START, DATA, STOP: clear_s = 1'b0;
      default:           clear_s = 1'b1;
    endcase
  end

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_s),
    .bit_tick (bit_tick_s)
  );

  // Transmit FSM. Outputs are registered together with the state so each
  // output is exactly the decode of the state the FSM is now in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= {DATA_W{1'b0}};
      bit_cnt_r <= 3'd0;
      tx_r      <= TX_IDLE;
      fifo_rd_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tx_r <= TX_IDLE;
          if (en && !fifo_empty) begin
            state_r   <= REQ;
            fifo_rd_r <= 1'b1;
            busy_r    <= 1'b1;
          end else begin
            state_r   <= IDLE;
            fifo_rd_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        end
        REQ: begin
          // Pop is a single cycle; data arrives while we sit in LOAD.
          state_r   <= LOAD;
          fifo_rd_r <= 1'b0;
        end
        LOAD: begin
          shift_r   <= fifo_dout;
          bit_cnt_r <= 3'd0;
          state_r   <= START;
          tx_r      <= 1'b0;
        end
        START: begin
          if (bit_tick_s) begin
            state_r <= DATA;
            tx_r    <= shift_r[0];
          end
        end
        DATA: begin
          if (bit_tick_s) begin
            shift_r <= shift_r >> 1;
            if (bit_cnt_r == LAST_BIT) begin
              state_r <= STOP;
              tx_r    <= TX_IDLE;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              // Next bit is the one about to land in shift_r[0].
              tx_r      <= shift_r[1];
            end
          end
        end
        STOP: begin
          if (bit_tick_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          shift_r   <= {DATA_W{1'b0}};
          bit_cnt_r <= 3'd0;
          tx_r      <= TX_IDLE;
          fifo_rd_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = tx_r;
  assign fifo_rd    = fifo_rd_r;
  assign busy       = busy_r;
  // Decoded from registered state and the timer's registered count only.
  assign frame_done = (state_r == STOP) && bit_tick_s;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int N  = 4;
  localparam int FL = 2 + 10 * N;   // REQ + LOAD + START..STOP

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd, tx, busy, frame_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt = 0;
  logic [7:0] fq[$];
  logic tx_log[$];
  logic rd_log[$];
  logic done_log[$];
  logic busy_log[$];

  // Line levels for START, 8 data bits LSB first, STOP.
  int exp_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int exp_3c[10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-timeline reference: a frame is a sequence of FL cycles starting the
  // cycle after an enabled, non-empty idle cycle.
  logic       m_act = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;
  logic       seen_rst = 1'b0;

  always @(posedge clk) begin
    int b;
    int e_tx;
    if (rst) begin
      m_act = 1'b0;
      m_k = 0;
      seen_rst = 1'b1;
    end else if (m_act) begin
      if (m_k == FL - 1) m_act = 1'b0;
      else m_k++;
    end else if (en && !fifo_empty) begin
      m_act = 1'b1;
      m_k = 0;
      m_byte = fq[0];
    end
    #1;
    if (seen_rst) begin
      e_tx = 1;
      if (m_act && m_k >= 2) begin
        b = (m_k - 2) / N;
        if (b == 0) e_tx = 0;
        else if (b <= 8) e_tx = int'(m_byte[b-1]);
        else e_tx = 1;
      end
      check("tx", tx, e_tx);
      check("fifo_rd", fifo_rd, (m_act && m_k == 0) ? 1 : 0);
      check("busy", busy, m_act ? 1 : 0);
      check("frame_done", frame_done, (m_act && m_k == FL - 1) ? 1 : 0);
    end
    tx_log.push_back(tx);
    rd_log.push_back(fifo_rd);
    done_log.push_back(frame_done);
    busy_log.push_back(busy);
    if (fifo_rd) rd_cnt++;
  end

  // One clock: the FIFO model pops on the cycle fifo_rd is seen.
  task automatic cyc();
    @(negedge clk);
    if (fifo_rd && fq.size() > 0) fifo_dout = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    rd_log.delete();
    done_log.delete();
    busy_log.delete();
  endtask

  function automatic int count_ones(input int which);
    int c = 0;
    if (which == 0) begin
      foreach (tx_log[i]) if (!tx_log[i]) c++;
    end else begin
      foreach (done_log[i]) if (done_log[i]) c++;
    end
    return c;
  endfunction

  initial begin
    int rd0;
    int pushed;
    rst = 1'b1;
    en = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    en = 1'b1;

    // 1: idle with empty FIFO
    clear_logs();
    repeat (50) cyc();
    check("t1_rd_cnt", rd_cnt, 0);
    check("t1_tx_low_cycles", count_ones(0), 0);
    check("t1_tx_last", tx_log[49], 1);
    check("t1_busy_last", busy_log[49], 0);

    // 2: single byte 0xA5
    clear_logs();
    rd0 = rd_cnt;
    push(8'hA5);
    repeat (48) cyc();
    check("t2_pops", rd_cnt - rd0, 1);
    check("t2_rd_first", rd_log[0], 1);
    check("t2_rd_load", rd_log[1], 0);
    for (int bi = 0; bi < 10; bi++)
      for (int j = 0; j < N; j++)
        check($sformatf("t2_bit%0d_%0d", bi, j), tx_log[2 + N * bi + j], exp_a5[bi]);
    check("t2_done_count", count_ones(1), 1);
    check("t2_done_at_40", done_log[41], 1);
    check("t2_busy_40", busy_log[41], 1);
    check("t2_busy_after", busy_log[42], 0);

    // 3: back-to-back 0x00, 0xFF
    clear_logs();
    rd0 = rd_cnt;
    push(8'h00);
    push(8'hFF);
    repeat (100) cyc();
    check("t3_pops", rd_cnt - rd0, 2);
    check("t3_done1", done_log[41], 1);
    for (int g = 42; g < 45; g++)
      check($sformatf("t3_gap%0d", g - 42), tx_log[g], 1);
    check("t3_start2", tx_log[45], 0);
    check("t3_rd2", rd_log[43], 1);
    for (int bi = 1; bi <= 8; bi++) begin
      check($sformatf("t3_f1_bit%0d", bi), tx_log[2 + N * bi + 1], 0);
      check($sformatf("t3_f2_bit%0d", bi), tx_log[45 + N * bi + 1], 1);
    end
    check("t3_done_count", count_ones(1), 2);

    // 4: drop en mid-DATA, then hold off with en low
    clear_logs();
    rd0 = rd_cnt;
    push(8'h3C);
    repeat (20) cyc();
    en = 1'b0;
    repeat (30) cyc();
    for (int bi = 0; bi < 10; bi++)
      check($sformatf("t4_bit%0d", bi), tx_log[2 + N * bi + 1], exp_3c[bi]);
    check("t4_done", done_log[41], 1);
    push(8'h55);
    clear_logs();
    repeat (10) cyc();
    check("t4_pops_en_low", rd_cnt - rd0, 1);
    check("t4_tx_low_cycles", count_ones(0), 0);
    clear_logs();
    en = 1'b1;
    cyc();
    check("t4_req_next", rd_log[0], 1);
    repeat (45) cyc();
    check("t4_fifo_drained", fq.size(), 0);

    // 5: reset during third data bit of 0x81
    clear_logs();
    rd0 = rd_cnt;
    push(8'h81);
    repeat (15) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t5_bit2_level", tx_log[14], 0);
    check("t5_busy_before", busy_log[14], 1);
    check("t5_tx_after_rst", tx_log[15], 1);
    check("t5_busy_after_rst", busy_log[15], 0);
    repeat (20) cyc();
    check("t5_pops", rd_cnt - rd0, 1);
    check("t5_fifo_count", fq.size(), 0);

    // 6: random bytes, random gaps and enable toggles
    rd0 = rd_cnt;
    pushed = 0;
    for (int i = 0; i < 1500; i++) begin
      cyc();
      if ($urandom_range(0, 29) == 0 && pushed < 25) begin
        push(8'($urandom_range(0, 255)));
        pushed++;
      end
      if ($urandom_range(0, 99) == 0) en = ~en;
    end
    en = 1'b1;
    repeat (1200) cyc();
    check("t6_pops", rd_cnt - rd0, pushed);
    check("t6_fifo_drained", fq.size(), 0);
    check("t6_idle_end", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
